// File: rtl/score_keeper.sv
// score_keeper: goal detection, per-player scores and rally sequencing; optional SERVE_ALTERNATE_EN
module score_keeper #(
  parameter int SCREEN_W    = 640,
  parameter int WIN_SCORE   = 9,
  parameter int HOLD_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic [9:0] ball_x,
  input  logic [5:0] ball_width,
  input  logic       start,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       serve,
  output logic       pause,
  output logic       serve_dir,
  output logic       game_over,
  output logic       winner
);
  typedef enum logic [2:0] {IDLE, PLAY, HOLD, SERVE, OVER} state_t;
  state_t state_q, state_d;
  logic [3:0] score_l_q, score_l_d, score_r_q, score_r_d;
  logic [7:0] cnt_q, cnt_d;
  logic serve_q, serve_d, pause_q, pause_d, game_over_q, game_over_d, winner_q, winner_d;
  logic goal_r, goal_l;
`ifdef SERVE_ALTERNATE_EN
  logic dir_q, dir_d;
`endif
  assign goal_r = ball_x == '0;
  assign goal_l = ({1'b0, ball_x} + 11'(ball_width)) >= 11'(SCREEN_W);
  // next state, scores and hold counter; goal_r takes priority when both sides hit together
  always_comb begin
    state_d   = state_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    cnt_d     = cnt_q;
    winner_d  = winner_q;
`ifdef SERVE_ALTERNATE_EN
    dir_d     = dir_q;
`endif
    case (state_q)
      IDLE: state_d = start ? SERVE : IDLE;
      PLAY: if (frame_tick && (goal_r || goal_l)) begin
        if (goal_r) score_r_d = score_r_q + 4'd1;
        else        score_l_d = score_l_q + 4'd1;
`ifdef SERVE_ALTERNATE_EN
        dir_d = goal_r;
`endif
        if ((goal_r ? score_r_q : score_l_q) == 4'(WIN_SCORE - 1)) begin
          state_d  = OVER;
          winner_d = goal_r;
        end else begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      HOLD: if (frame_tick) begin
        state_d = (cnt_q == 8'(HOLD_FRAMES - 1)) ? SERVE : HOLD;
        cnt_d   = (cnt_q == 8'(HOLD_FRAMES - 1)) ? 8'd0 : cnt_q + 8'd1;
      end
      SERVE: state_d = PLAY;
      OVER: if (start) begin
        state_d   = SERVE;
        score_l_d = '0;
        score_r_d = '0;
`ifdef SERVE_ALTERNATE_EN
        dir_d     = 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase
  end
  // outputs are decoded from the next state so they register alongside it
  always_comb begin
    serve_d     = state_d == SERVE;
    pause_d     = state_d != PLAY;
    game_over_d = state_d == OVER;
  end
  // state and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      score_l_q   <= '0;
      score_r_q   <= '0;
      cnt_q       <= '0;
      serve_q     <= 1'b0;
      pause_q     <= 1'b1;
      game_over_q <= 1'b0;
      winner_q    <= 1'b0;
`ifdef SERVE_ALTERNATE_EN
      dir_q       <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      cnt_q       <= cnt_d;
      serve_q     <= serve_d;
      pause_q     <= pause_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
`ifdef SERVE_ALTERNATE_EN
      dir_q       <= dir_d;
`endif
    end
  end
  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign serve     = serve_q;
  assign pause     = pause_q;
  assign game_over = game_over_q;
  assign winner    = winner_q;
`ifdef SERVE_ALTERNATE_EN
  assign serve_dir = dir_q;
`else
  assign serve_dir = 1'b1;
`endif
endmodule
